// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline control modules.
//   stall_state_e : stall controller FSM encoding (RUN / MDU_WAIT)
//   MAX_WAIT_DEF  : default mult/div wait watchdog limit in cycles
//   WAIT_CNT_W    : width of the mult/div wait counter
package pipe_stall_ctrl_pkg;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MDU_WAIT = 1'b1
  } stall_state_e;

  localparam int MAX_WAIT_DEF = 64;
  localparam int WAIT_CNT_W   = 8;

endpackage

// File: rtl/pipe_stall_ctrl_perf_counter.sv
// Generic performance event counter.
//   clk   : clock
//   rst_n : asynchronous active-low reset, clears the count
//   clr   : synchronous clear, wins over inc
//   inc   : count one event this cycle
//   cnt   : current count, wraps modulo 2^CNT_W
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller for the 5-stage core.
// Turns the ID-stage hazard requests into PC / IF/ID / ID/EX / EX controls,
// tracks multi-cycle mult/div occupancy with a watchdog, and counts
// bubbles and flushes.
//   clk, rst_n      : clock, asynchronous active-low reset
//   branchbubble    : branch operand not ready -> hold ID, bubble EX
//   loaduse_bubble  : load-use hazard -> hold ID, bubble EX
//   id_redirect     : taken branch/jump resolved in ID
//   mem_ready       : data memory access completes (0 = wait)
//   mdu_start       : mult/div issued from EX
//   mdu_done        : mult/div result valid
//   perf_clr        : clear counters and hazard_err
//   pc_we, ifid_we  : register write enables
//   ifid_flush      : NOP into IF/ID
//   idex_flush      : NOP into ID/EX
//   ex_hold         : freeze ID/EX and EX/MEM
//   mdu_busy        : waiting on mult/div
//   hazard_err      : sticky watchdog flag
//   bubble_cnt      : cycles with idex_flush
//   flush_cnt       : cycles with ifid_flush
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             branchbubble,
  input  logic             loaduse_bubble,
  input  logic             id_redirect,
  input  logic             mem_ready,
  input  logic             mdu_start,
  input  logic             mdu_done,
  input  logic             perf_clr,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             ex_hold,
  output logic             mdu_busy,
  output logic             hazard_err,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MAX_WAIT - 1);

  stall_state_e            state_q, state_d;
  logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                    wd_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    ex_hold    = 1'b0;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    wd_fire    = 1'b0;

    if (!mem_ready) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      ex_hold = 1'b1;
    end else if (state_q == ST_MDU_WAIT && !mdu_done) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      ex_hold = 1'b1;
    end else if (branchbubble || loaduse_bubble) begin
      // The branch may have resolved on stale operands, so a redirect
      // raised alongside a bubble is dropped.
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
    end else if (id_redirect) begin
      ifid_flush = 1'b1;
    end

    // A memory wait freezes the whole FSM, including the watchdog.
    if (mem_ready) begin
      if (state_q == ST_RUN) begin
        if (mdu_start) begin
          state_d    = ST_MDU_WAIT;
          wait_cnt_d = '0;
        end
      end else begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (mdu_done) begin
          state_d = ST_RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
          wd_fire    = 1'b1;
        end
      end
    end

    // While reset is held, keep the pipeline frozen and full of NOPs.
    if (!rst_n) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      ex_hold    = 1'b0;
    end
  end

  assign mdu_busy = (state_q == ST_MDU_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hazard_err <= 1'b0;
    end else if (perf_clr) begin
      hazard_err <= 1'b0;
    end else if (wd_fire) begin
      hazard_err <= 1'b1;
    end
  end

  perf_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (perf_clr),
    .inc   (idex_flush),
    .cnt   (bubble_cnt)
  );

  perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (perf_clr),
    .inc   (ifid_flush),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic branchbubble, loaduse_bubble, id_redirect, mem_ready;
  logic mdu_start, mdu_done, perf_clr;

  logic        pc_we, ifid_we, ifid_flush, idex_flush, ex_hold, mdu_busy, hazard_err;
  logic [31:0] bubble_cnt, flush_cnt;

  logic        pc_we_b, ifid_we_b, ifid_flush_b, idex_flush_b, ex_hold_b, mdu_busy_b, hazard_err_b;
  logic [3:0]  bubble_cnt_b, flush_cnt_b;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .branchbubble(branchbubble), .loaduse_bubble(loaduse_bubble),
    .id_redirect(id_redirect), .mem_ready(mem_ready),
    .mdu_start(mdu_start), .mdu_done(mdu_done), .perf_clr(perf_clr),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .ex_hold(ex_hold), .mdu_busy(mdu_busy),
    .hazard_err(hazard_err), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  pipe_stall_ctrl #(.MAX_WAIT(4), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .branchbubble(branchbubble), .loaduse_bubble(loaduse_bubble),
    .id_redirect(id_redirect), .mem_ready(mem_ready),
    .mdu_start(mdu_start), .mdu_done(mdu_done), .perf_clr(perf_clr),
    .pc_we(pc_we_b), .ifid_we(ifid_we_b), .ifid_flush(ifid_flush_b),
    .idex_flush(idex_flush_b), .ex_hold(ex_hold_b), .mdu_busy(mdu_busy_b),
    .hazard_err(hazard_err_b), .bubble_cnt(bubble_cnt_b), .flush_cnt(flush_cnt_b)
  );

  // {pc_we, ifid_we, ifid_flush, idex_flush, ex_hold, mdu_busy}
  function automatic logic [5:0] ctl_a();
    return {pc_we, ifid_we, ifid_flush, idex_flush, ex_hold, mdu_busy};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Set inputs just after a rising edge, then wait to the falling edge to sample.
  task automatic apply(input logic bb, input logic lu, input logic rd, input logic mr,
                       input logic st, input logic dn, input logic clr);
    branchbubble = bb; loaduse_bubble = lu; id_redirect = rd; mem_ready = mr;
    mdu_start = st; mdu_done = dn; perf_clr = clr;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string      name;
    logic [6:0] in;   // {bb, lu, redirect, mem_ready, start, done, perf_clr}
    logic [5:0] exp;  // {pc_we, ifid_we, ifid_flush, idex_flush, ex_hold, mdu_busy}
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] saved;

    vecs[0] = '{"idle",           7'b0001000, 6'b110000};
    vecs[1] = '{"memwait",        7'b0000000, 6'b000010};
    vecs[2] = '{"memwait_bb_rd",  7'b1010000, 6'b000010};
    vecs[3] = '{"branchbubble",   7'b1001000, 6'b000100};
    vecs[4] = '{"loaduse",        7'b0101000, 6'b000100};
    vecs[5] = '{"loaduse_rd",     7'b0111000, 6'b000100};
    vecs[6] = '{"redirect",       7'b0011000, 6'b111000};
    vecs[7] = '{"redirect_done",  7'b0011010, 6'b111000};

    // Reset held for 3 cycles
    rst_n = 1'b0;
    branchbubble = 0; loaduse_bubble = 0; id_redirect = 0; mem_ready = 1;
    mdu_start = 0; mdu_done = 0; perf_clr = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ctl", ctl_a(), 6'b001100);
    end
    chk("rst_bubble_cnt", bubble_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    chk("rst_hazard_err", hazard_err, 0);
    tick();
    rst_n = 1'b1;
    apply(0, 0, 0, 1, 0, 0, 0);
    chk("post_rst_ctl", ctl_a(), 6'b110000);
    tick();
    chk("post_rst_bubble_cnt", bubble_cnt, 0);

    // Branch bubble then redirect
    apply(1, 0, 1, 1, 0, 0, 0);
    chk("bb_cyc1_ctl", ctl_a(), 6'b000100);
    tick();
    apply(0, 0, 1, 1, 0, 0, 0);
    chk("bb_cyc2_ctl", ctl_a(), 6'b111000);
    tick();
    apply(0, 0, 0, 1, 0, 0, 0);
    chk("bb_bubble_cnt", bubble_cnt, 1);
    chk("bb_flush_cnt", flush_cnt, 1);
    tick();

    // Priority table, all applied from RUN
    for (int i = 0; i < 8; i++) begin
      apply(vecs[i].in[6], vecs[i].in[5], vecs[i].in[4], vecs[i].in[3],
            vecs[i].in[2], vecs[i].in[1], vecs[i].in[0]);
      chk(vecs[i].name, ctl_a(), vecs[i].exp);
      tick();
    end

    // Memory wait dominates a load-use bubble and an mdu_start
    saved = bubble_cnt;
    apply(0, 1, 0, 0, 1, 0, 0);
    chk("memdom_ctl", ctl_a(), 6'b000010);
    tick();
    apply(0, 0, 0, 1, 0, 0, 0);
    chk("memdom_busy", mdu_busy, 0);
    chk("memdom_bubble_cnt", bubble_cnt, saved);
    tick();

    // MDU wait: start at cycle 0, done at cycle 5 (bubble during wait is held off)
    apply(0, 0, 0, 1, 1, 0, 0);
    chk("mdu_c0_ctl", ctl_a(), 6'b110000);
    tick();
    for (int c = 1; c <= 4; c++) begin
      apply((c == 3) ? 1'b1 : 1'b0, 0, 0, 1, 0, 0, 0);
      chk("mdu_wait_ctl", ctl_a(), 6'b000011);
      tick();
    end
    apply(0, 0, 0, 1, 0, 1, 0);
    chk("mdu_c5_ctl", ctl_a(), 6'b110001);
    tick();
    apply(0, 0, 0, 1, 0, 0, 0);
    chk("mdu_c6_busy", mdu_busy, 0);
    // The MAX_WAIT=4 instance timed out during that wait
    chk("b_wd_during_mdu", hazard_err_b, 1);
    tick();

    // perf_clr clears hazard_err
    apply(0, 0, 0, 1, 0, 0, 1);
    tick();
    apply(0, 0, 0, 1, 0, 0, 0);
    chk("b_clr_hazard", hazard_err_b, 0);
    tick();

    // Watchdog, MAX_WAIT=4, mdu_done never asserted
    apply(0, 0, 0, 1, 1, 0, 0);
    tick();
    for (int c = 1; c <= 4; c++) begin
      apply(0, 0, 0, 1, 0, 0, 0);
      chk("wd_busy", mdu_busy_b, 1);
      chk("wd_err_pending", hazard_err_b, 0);
      tick();
    end
    apply(0, 0, 0, 1, 0, 0, 0);
    chk("wd_err_set", hazard_err_b, 1);
    chk("wd_state_run", mdu_busy_b, 0);
    chk("wd_pc_we", pc_we_b, 1);
    tick();
    // Clear, and release the default instance from its still-running wait
    apply(0, 0, 0, 1, 0, 1, 1);
    tick();
    apply(0, 0, 0, 1, 0, 0, 0);
    chk("wd_err_cleared", hazard_err_b, 0);
    chk("wd_bubble_cleared", bubble_cnt_b, 0);
    chk("a_busy_released", mdu_busy, 0);
    tick();

    // Wrap: 17 bubble cycles on a 4-bit counter
    for (int c = 0; c < 17; c++) begin
      apply(1, 0, 0, 1, 0, 0, 0);
      tick();
    end
    apply(0, 0, 0, 1, 0, 0, 0);
    chk("wrap_bubble_cnt_b", bubble_cnt_b, 1);
    chk("wrap_bubble_cnt_a", bubble_cnt, 17);
    tick();
    // perf_clr during a bubble cycle
    apply(1, 0, 0, 1, 0, 0, 1);
    tick();
    apply(0, 0, 0, 1, 0, 0, 0);
    chk("clr_bubble_cnt_b", bubble_cnt_b, 0);
    chk("clr_bubble_cnt_a", bubble_cnt, 0);
    tick();

    // Mid-wait reset abandons MDU_WAIT immediately
    apply(0, 0, 0, 1, 1, 0, 0);
    tick();
    apply(0, 0, 0, 1, 0, 0, 0);
    chk("midrst_busy_before", mdu_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ctl", ctl_a(), 6'b001100);
    tick();
    rst_n = 1'b1;
    apply(0, 0, 0, 1, 0, 0, 0);
    chk("midrst_after_ctl", ctl_a(), 6'b110000);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
